// File: rtl/gpu_pkg.sv
// Shared opcodes, command-word field offsets and engine states for gpu_draw_engine.
// FILL_RECT is a legal opcode only when GPU_RECT_FILL_EN is defined.
package gpu_pkg;

  typedef enum logic [3:0] {
    OP_SET_XY1   = 4'b0001,
    OP_SET_XY2   = 4'b0010,
    OP_DRAW_LINE = 4'b0100,
    OP_FILL_RECT = 4'b1000
  } opcode_e;

  localparam int X_LSB  = 0;
  localparam int Y_LSB  = 12;
  localparam int G_LSB  = 8;
  localparam int B_LSB  = 16;
  localparam int OP_LSB = 28;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_LINE_SETUP,
    S_LINE,
    S_RECT_SETUP,
    S_RECT
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_SET_XY1, OP_SET_XY2, OP_DRAW_LINE: return 1'b1;
`ifdef GPU_RECT_FILL_EN
      OP_FILL_RECT:                         return 1'b1;
`endif
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; read data is the current head word.
module gpu_cmd_fifo #(
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_BITS:0]    wr_ptr;
  logic [PTR_BITS:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                 (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
  assign rdata = mem[rd_ptr[PTR_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which words are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_BITS-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpu_draw_engine.sv
// Queued GPU draw engine: APB command port -> FIFO -> Bresenham line / rectangle fill pixel stream.
// Rectangle fill is built only when GPU_RECT_FILL_EN is defined.
module gpu_draw_engine
  import gpu_pkg::*;
#(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             pAddr_i,
  input  logic [31:0]             pDataWrite_i,
  input  logic                    pSel_i,
  input  logic                    pEnable_i,
  input  logic                    pWrite_i,
  output logic                    pReady_o,
  output logic                    pSlvErr_o,
  output logic [WIDTH_BITS-1:0]   x_o,
  output logic [HEIGHT_BITS-1:0]  y_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic                    pixel_valid_o,
  input  logic                    pixel_ready_i,
  output logic                    busy_o
);

  localparam int ERR_BITS = ((WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS) + 2;

  logic        fifo_full, fifo_empty, push, pop, access, handshake;
  logic [31:0] fifo_data, cmd;
  state_e      state, state_next;
  opcode_e     cmd_op;

  logic [WIDTH_BITS-1:0]  x1, x2, cur_x;
  logic [HEIGHT_BITS-1:0] y1, y2, cur_y;
  logic                   sx_neg, sy_neg, step_x, step_y, line_done;
  logic signed [ERR_BITS-1:0] dx, dy, err, err_next, dx_abs, dy_abs, dy_neg;
  logic signed [ERR_BITS:0]   e2, dx_ext, dy_ext;

  // Bits of the address and command word that carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{pAddr_i, cmd};

  assign access    = pSel_i & pEnable_i & pWrite_i & pReady_o;
  assign push      = access & is_legal_op(pDataWrite_i[OP_LSB +: 4]);
  assign pSlvErr_o = access & !is_legal_op(pDataWrite_i[OP_LSB +: 4]);
  assign pReady_o  = !fifo_full;
  assign busy_o    = (state != S_IDLE) | !fifo_empty;

  gpu_cmd_fifo #(
    .DATA_BITS (32),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (pDataWrite_i),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_op = opcode_e'(cmd[OP_LSB +: 4]);
  assign x_o    = cur_x;
  assign y_o    = cur_y;

  // Line setup terms and one Bresenham step from the current error.
  assign dx_abs    = (x2 >= x1) ? ERR_BITS'(x2 - x1) : ERR_BITS'(x1 - x2);
  assign dy_abs    = (y2 >= y1) ? ERR_BITS'(y2 - y1) : ERR_BITS'(y1 - y2);
  assign dy_neg    = -dy_abs;
  assign e2        = {err, 1'b0};
  assign dx_ext    = dx;
  assign dy_ext    = dy;
  assign step_x    = (e2 >= dy_ext);
  assign step_y    = (e2 <= dx_ext);
  assign line_done = (cur_x == x2) && (cur_y == y2);

  always_comb begin
    err_next = err;
    if (step_x) err_next = err_next + dy;
    if (step_y) err_next = err_next + dx;
  end

`ifdef GPU_RECT_FILL_EN
  logic [WIDTH_BITS-1:0]  x_lo, x_hi;
  logic [HEIGHT_BITS-1:0] y_lo, y_hi;
  logic                   rect_done;
  assign rect_done     = (cur_x == x_hi) && (cur_y == y_hi);
  assign pixel_valid_o = (state == S_LINE) || (state == S_RECT);
`else
  assign pixel_valid_o = (state == S_LINE);
`endif
  assign handshake = pixel_valid_o & pixel_ready_i;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a latch behind.
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty) begin
        pop        = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (cmd_op == OP_DRAW_LINE) state_next = S_LINE_SETUP;
`ifdef GPU_RECT_FILL_EN
        else if (cmd_op == OP_FILL_RECT) state_next = S_RECT_SETUP;
`endif
        else state_next = S_IDLE;
      end
      S_LINE_SETUP: state_next = S_LINE;
      S_LINE:       if (handshake && line_done) state_next = S_IDLE;
`ifdef GPU_RECT_FILL_EN
      S_RECT_SETUP: state_next = S_RECT;
      S_RECT:       if (handshake && rect_done) state_next = S_IDLE;
`endif
      default:      state_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd    <= '0;
      x1     <= '0;
      y1     <= '0;
      x2     <= '0;
      y2     <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      r_o    <= '0;
      g_o    <= '0;
      b_o    <= '0;
`ifdef GPU_RECT_FILL_EN
      x_lo   <= '0;
      x_hi   <= '0;
      y_lo   <= '0;
      y_hi   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (pop) cmd <= fifo_data;
        S_DECODE: begin
          case (cmd_op)
            OP_SET_XY1: begin
              x1 <= cmd[X_LSB +: WIDTH_BITS];
              y1 <= cmd[Y_LSB +: HEIGHT_BITS];
            end
            OP_SET_XY2: begin
              x2 <= cmd[X_LSB +: WIDTH_BITS];
              y2 <= cmd[Y_LSB +: HEIGHT_BITS];
            end
            default: begin
              r_o <= cmd[0 +: CHANNEL_BITS];
              g_o <= cmd[G_LSB +: CHANNEL_BITS];
              b_o <= cmd[B_LSB +: CHANNEL_BITS];
            end
          endcase
        end
        S_LINE_SETUP: begin
          cur_x  <= x1;
          cur_y  <= y1;
          dx     <= dx_abs;
          dy     <= dy_neg;
          err    <= dx_abs + dy_neg;
          sx_neg <= (x2 < x1);
          sy_neg <= (y2 < y1);
        end
        S_LINE: if (handshake && !line_done) begin
          if (step_x) cur_x <= sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
          if (step_y) cur_y <= sy_neg ? cur_y - 1'b1 : cur_y + 1'b1;
          err <= err_next;
        end
`ifdef GPU_RECT_FILL_EN
        S_RECT_SETUP: begin
          x_lo  <= (x1 < x2) ? x1 : x2;
          x_hi  <= (x1 < x2) ? x2 : x1;
          y_lo  <= (y1 < y2) ? y1 : y2;
          y_hi  <= (y1 < y2) ? y2 : y1;
          cur_x <= (x1 < x2) ? x1 : x2;
          cur_y <= (y1 < y2) ? y1 : y2;
        end
        S_RECT: if (handshake && !rect_done) begin
          if (cur_x == x_hi) begin
            cur_x <= x_lo;
            cur_y <= cur_y + 1'b1;
          end else begin
            cur_x <= cur_x + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_draw_engine.sv
// Directed scoreboard bench for gpu_draw_engine: lines, back-pressure, FIFO full, errors, fill, reset.
module tb_gpu_draw_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = '0, pdata = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pixel_ready = 1'b0;
  logic        pready, pslverr, valid, busy;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [7:0]  r, g, b;

  int checks = 0;
  int errors = 0;
  int pix_count = 0;
  logic [42:0] sb[$];
  logic        held = 1'b0;
  logic [42:0] hold_val = '0;
  wire  [42:0] pix_now = {x, y, b, g, r};

  gpu_draw_engine #(
    .WIDTH_BITS(10), .HEIGHT_BITS(9), .CHANNEL_BITS(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .pAddr_i(paddr), .pDataWrite_i(pdata),
    .pSel_i(psel), .pEnable_i(penable), .pWrite_i(pwrite),
    .pReady_o(pready), .pSlvErr_o(pslverr),
    .x_o(x), .y_o(y), .r_o(r), .g_o(g), .b_o(b),
    .pixel_valid_o(valid), .pixel_ready_i(pixel_ready), .busy_o(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pix(input int px, input int py, input logic [31:0] colour);
    sb.push_back({10'(px), 9'(py), colour[23:0]});
  endtask

  task automatic apb_write(input logic [31:0] data, input logic exp_err, input string tag);
    int waits = 0;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; pdata = data;
    step();
    penable = 1'b1;
    @(negedge clk);
    while (!pready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    check({tag, "_ready"}, pready, 1'b1);
    check({tag, "_slverr"}, pslverr, exp_err);
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 1000) begin
      step();
      n++;
    end
    check({tag, "_drained"}, n < 1000, 1'b1);
  endtask

  // Scoreboard monitor: compares each accepted pixel and checks outputs hold under back-pressure.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) check("hold", {valid, pix_now}, {1'b1, hold_val});
        if (valid && pixel_ready) begin
          check("pixel_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) check($sformatf("pixel%0d", pix_count), pix_now, sb.pop_front());
          pix_count++;
        end
        held     = valid && !pixel_ready;
        hold_val = pix_now;
      end
    end
  end

  initial begin
    int lx[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int ly[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int base;
    int n;

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_pready", pready, 1'b1);
    check("rst_flags", {valid, busy, pslverr}, 3'b000);
    check("rst_xy", {x, y}, '0);
    check("rst_rgb", {r, g, b}, '0);
    step();

    // 1: line (0,0)->(7,3), latency and one pixel per cycle
    pixel_ready = 1'b1;
    apb_write(32'h1000_0000, 1'b0, "l1_xy1");
    apb_write(32'h2000_3007, 1'b0, "l1_xy2");
    for (int i = 0; i < 8; i++) expect_pix(lx[i], ly[i], 32'h40AA_BD3E);
    apb_write(32'h40AA_BD3E, 1'b0, "l1_draw");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("l1_valid_c%0d", k + 1), valid, (k >= 3 && k < 11));
    end
    step();
    wait_idle("l1");

    // 2: reversed line (7,3)->(0,0)
    apb_write(32'h1000_3007, 1'b0, "l2_xy1");
    apb_write(32'h2000_0000, 1'b0, "l2_xy2");
    for (int i = 7; i >= 0; i--) expect_pix(lx[i], ly[i], 32'h4012_3456);
    apb_write(32'h4012_3456, 1'b0, "l2_draw");
    wait_idle("l2");

    // 3: back-pressure after the 3rd pixel
    apb_write(32'h1000_0000, 1'b0, "bp_xy1");
    apb_write(32'h2000_3007, 1'b0, "bp_xy2");
    for (int i = 0; i < 8; i++) expect_pix(lx[i], ly[i], 32'h4055_6677);
    base = pix_count;
    apb_write(32'h4055_6677, 1'b0, "bp_draw");
    n = 0;
    while (pix_count - base < 3 && n < 100) begin step(); n++; end
    check("bp_third_pixel", n < 100, 1'b1);
    pixel_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_frozen", {valid, x, y}, {1'b1, 10'd3, 9'd1});
    end
    step();
    pixel_ready = 1'b1;
    wait_idle("bp");
    check("bp_total", pix_count - base, 8);

    // 4: FIFO full behind a stalled draw; commands run in order
    pixel_ready = 1'b0;
    for (int i = 0; i < 8; i++) expect_pix(lx[i], ly[i], 32'h4000_0001);
    apb_write(32'h4000_0001, 1'b0, "ff_draw0");
    n = 0;
    while (!valid && n < 50) begin step(); n++; end
    check("ff_stalled", valid, 1'b1);
    for (int i = 2; i <= 4; i++) expect_pix(i, 5, 32'h4000_0002);
    for (int i = 5; i <= 7; i++) expect_pix(2, i, 32'h4000_0003);
    apb_write(32'h1000_5002, 1'b0, "ff_w1");
    apb_write(32'h2000_5004, 1'b0, "ff_w2");
    apb_write(32'h4000_0002, 1'b0, "ff_w3");
    apb_write(32'h2000_7002, 1'b0, "ff_w4");
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; pdata = 32'h4000_0003;
    step();
    penable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ff_pready_low", {pready, busy}, 2'b01);
    end
    step();
    pixel_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pready && n < 200) begin @(negedge clk); n++; end
    check("ff_w5_ready", pready, 1'b1);
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    wait_idle("ff");

    // 5: illegal opcode and rectangle fill
    apb_write(32'hF000_0000, 1'b1, "illegal");
    repeat (3) begin
      @(negedge clk);
      check("illegal_quiet", {busy, pslverr, valid}, 3'b000);
    end
    step();
    apb_write(32'h1000_1002, 1'b0, "fill_xy1");
    apb_write(32'h2000_2004, 1'b0, "fill_xy2");
`ifdef GPU_RECT_FILL_EN
    for (int j = 1; j <= 2; j++)
      for (int i = 2; i <= 4; i++) expect_pix(i, j, 32'h8000_00C0);
    apb_write(32'h8000_00C0, 1'b0, "fill");
    wait_idle("fill");
`else
    apb_write(32'h8000_00C0, 1'b1, "fill_disabled");
    repeat (3) begin
      @(negedge clk);
      check("fill_disabled_quiet", {busy, valid}, 2'b00);
    end
    step();
`endif

    // 6: reset after the 3rd pixel discards the draw and the queued command
    apb_write(32'h1000_0000, 1'b0, "rs_xy1");
    apb_write(32'h2000_3007, 1'b0, "rs_xy2");
    for (int i = 0; i < 8; i++) expect_pix(lx[i], ly[i], 32'h4011_2233);
    base = pix_count;
    apb_write(32'h4011_2233, 1'b0, "rs_draw");
    apb_write(32'h4044_5566, 1'b0, "rs_queued");
    n = 0;
    while (pix_count - base < 3 && n < 100) begin step(); n++; end
    check("rs_third_pixel", n < 100, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rs_outputs", {valid, busy, x, y}, '0);
    check("rs_pready", pready, 1'b1);
    repeat (8) begin
      @(negedge clk);
      check("rs_stays_idle", {valid, busy}, 2'b00);
    end
    step();

    check("sb_final_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_draw_engine.md
# gpu_draw_engine

Parametrised, queued successor to the single-command GPU line drawer. It accepts drawing commands over the APB-style register port into a command FIFO, executes them in order, and emits pixels on a valid/ready stream toward the frame-buffer writer. Coordinate and channel widths are generic. The block adds back-pressure, a rectangle-fill mode and error signalling.

## Interface
- `WIDTH_BITS`, 10: x coordinate width; must be ≤12.
- `HEIGHT_BITS`, 9: y coordinate width; must be ≤12.
- `CHANNEL_BITS`, 8: width of each colour channel; must be ≤8.
- `FIFO_DEPTH`, 4: command FIFO entries; must be a power of two, ≥2.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pAddr_i` in 32: ignored; single command register.
- `pDataWrite_i` in 32: command word.
- `pSel_i`, `pEnable_i`, `pWrite_i` in 1 each: APB control.
- `pReady_o` out 1: access may complete.
- `pSlvErr_o` out 1: illegal command in the access phase.
- `x_o` out `WIDTH_BITS`: pixel x.
- `y_o` out `HEIGHT_BITS`: pixel y.
- `r_o`, `g_o`, `b_o` out `CHANNEL_BITS` each: pixel colour.
- `pixel_valid_o` out 1: the pixel outputs are valid.
- `pixel_ready_i` in 1: the consumer accepts the pixel.
- `busy_o` out 1: a command is executing or the FIFO is non-empty.

## Operation
- **Command word fields:**
  - opcode = [31:28]
  - x = [WIDTH_BITS-1:0]
  - y = [12+HEIGHT_BITS-1:12]
  - r = [CHANNEL_BITS-1:0]
  - g = [8+:CHANNEL_BITS]
  - b = [16+:CHANNEL_BITS]
- **Opcodes:**
  - 4'b0001 SET_XY1: load point 1.
  - 4'b0010 SET_XY2: load point 2.
  - 4'b0100 DRAW_LINE: draw with the word's colour.
  - 4'b1000 FILL_RECT: see Configuration.
  - All others are illegal.
- **Write acceptance:**
  - A write completes in a cycle with pSel&pEnable&pWrite&pReady_o.
  - A legal opcode is pushed to the FIFO.
  - An illegal opcode is not pushed; pSlvErr_o=1 in that cycle.
- `pReady_o` = !fifo_full, combinational. Read accesses complete immediately and return nothing.
- **Program order:** XY1/XY2 registers update only when their command is executed, never when written. A SET during an active draw does not disturb that draw.
- **FSM:**
  - IDLE: FIFO non-empty → pop → DECODE.
  - DECODE: SET_* updates its register → IDLE. DRAW_LINE → LINE_SETUP. FILL_RECT → RECT_SETUP.
  - LINE_SETUP:
    - dx=|x2-x1|, dy=-|y2-y1|, sx/sy = ±1, err=dx+dy.
    - err is signed, max(WIDTH_BITS,HEIGHT_BITS)+2 bits.
    - Current point = XY1 → LINE.
  - LINE: Bresenham with inclusive endpoints. On each handshake:
    - At XY2 → IDLE.
    - Otherwise e2=2·err; if e2≥dy then err+=dy, x+=sx; if e2≤dx then err+=dx, y+=sy.
  - RECT_SETUP: bounds are the min/max of XY1/XY2; current point = (xmin,ymin) → RECT.
  - RECT: row-major scan, x fastest. The handshake at (xmax,ymax) → IDLE.
- XY1==XY2 emits exactly one pixel in either mode.
- Colour is latched at DECODE and held for the whole command.

## Timing
- **Reset values:** all outputs 0 except pReady_o=1. FIFO empty, XY registers 0, FSM in IDLE.
- **Latency:** a push at edge N into an empty, idle engine gives pixel_valid_o=1 from edge N+3 (IDLE, DECODE, SETUP).
- A SET command occupies 2 cycles (IDLE, DECODE).
- **Stream rules:**
  - While pixel_valid_o=1 and pixel_ready_i=0, all pixel outputs hold stable.
  - One pixel per cycle with ready held high.
  - pixel_valid_o drops the cycle after the last handshake unless the next command is already drawing.
- **Simultaneous push and pop on a full FIFO:** pReady_o stays 0 that cycle; no bypass.
- **rst mid-operation:** the next edge empties the FIFO, returns to IDLE and zeroes the outputs. The interrupted command is lost.
- busy_o = (state≠IDLE) | !fifo_empty.

## Configuration
- `GPU_RECT_FILL_EN` defined: FILL_RECT is legal and the RECT states exist.
- `GPU_RECT_FILL_EN` undefined: opcode 4'b1000 is illegal (pSlvErr_o=1, not queued) and no RECT logic is synthesised.

## Structure
- Package `gpu_pkg` holds:
  - Opcode enum
  - Field offset constants (X_LSB=0, Y_LSB=12, G_LSB=8, B_LSB=16)
  - FSM state enum
- Sub-module `gpu_cmd_fifo`: synchronous FIFO, parameters width 32 and `FIFO_DEPTH`, with full/empty flags. The engine FSM lives in the top module.

## Test plan
1. **Line:** XY1=0x1000_0000, XY2=0x2000_3007, DRAW 0x40AA_BD3E, ready=1 → pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2),(6,3),(7,3) on consecutive cycles, r=0x3E g=0xBD b=0xAA; first valid 3 cycles after the push.
2. **Reversed line:** XY1=(7,3), XY2=(0,0) → 8 pixels, first (7,3), last (0,0), x non-increasing.
3. **Back-pressure:** drop ready for 5 cycles after the 3rd pixel of case 1 → outputs frozen at (3,1); total still 8 pixels, no duplicates.
4. **FIFO full:** ready=0 and a running draw, then 5 further writes → the 5th write sees pReady_o=0 until a pop frees a slot, then completes; commands execute in order.
5. **Illegal/fill:**
   - Opcode 4'hF → pSlvErr_o=1 for one cycle, busy_o stays 0.
   - With the macro, XY (2,1)/(4,2) FILL → (2,1),(3,1),(4,1),(2,2),(3,2),(4,2).
   - Without the macro, FILL → pSlvErr_o=1.
6. **Reset mid-draw:** rst for one cycle after the 3rd pixel → pixel_valid_o=0, busy_o=0, x_o=y_o=0 at the next edge; queued commands discarded.
